usb_ctrl_ep: RTL and testbench
==============================

Name: usb_ctrl_ep

Overview:
- Control-transfer engine for a USB full-speed device with NUM_EP endpoints.
- Sits between the packet receiver/decoder and the packet transmitter.
- Parses the full 8-byte SETUP payload and executes no-data standard requests: SET_ADDRESS, SET_CONFIGURATION, SET_FEATURE / CLEAR_FEATURE (ENDPOINT_HALT).
- Drives ACK / STALL handshakes and the DATA1 zero-length status packet; commits the new device address only after the host ACKs the status stage.

Parameters:
- NUM_EP, 2: endpoint count (1..16); sets the width of ep_stall.
- TIMEOUT, 1023: clk cycles to wait for the host ACK after the ZLP; 10-bit counter.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- token_in  in  24  [7:0] PID, [14:8] address, [18:15] endpoint, [23:19] CRC5 (already checked); host handshakes arrive here with [7:0]=PID_ACK
- token_in_strb  in  1  one-cycle token/handshake valid
- data_in  in  8  received payload byte
- data_in_strb  in  1  data_in valid
- data_in_end  in  1  packet end, CRC good
- data_in_fail  in  1  packet aborted or CRC bad
- pid  in  8  PID of the current data packet
- data_o  out  8  byte to transmitter
- data_o_start_stop  out  1  one-cycle pulse: with data_o=PID starts a packet; alone ends it
- data_o_strb  in  1  transmitter consumed a byte or finished
- data_o_fail  in  1  transmit aborted
- dev_addr  out  7  current device address
- configured  out  1  SET_CONFIGURATION with nonzero value accepted
- ep_stall  out  NUM_EP  per-endpoint halt flags
- setup_pkt  out  64  last good SETUP payload, byte 0 in [7:0]
- setup_valid  out  1  one-cycle pulse on good SETUP

Behaviour:
- Reset values: all outputs 0; state IDLE; status_pending 0; pending_addr 0.
- Reset mid-packet aborts to IDLE. It does not preserve dev_addr.
- Token match: address==dev_addr and endpoint<NUM_EP. Non-matching tokens are ignored. Tokens are ignored outside IDLE and WAIT_ACK.
- IDLE, SETUP to EP0: go to RX_SETUP and clear byte counter cnt (4 bits).
  - SETUP to EP≠0: ignored.
- RX_SETUP: each data_in_strb stores data_in into setup_pkt byte cnt (bytes past 8 are discarded) and increments cnt, saturating at 9.
  - On data_in_end: require pid==PID_DATA0 and cnt==8; else go to IDLE with no handshake.
  - On data_in_fail: go to IDLE with no handshake.
  - On good end: pulse setup_valid, clear ep_stall[0], decode, then go to TX_HS with PID_ACK.
- Decode (wValue = bytes 3:2, wIndex = bytes 5:4, wLength = bytes 7:6; wLength must be 0, else unsupported):
  - bmRequestType 0x00, bRequest 5: pending_addr = wValue[6:0]; status_pending = 1.
  - 0x00 / 9: configured = (wValue[7:0]!=0); status_pending = 1.
  - 0x02 / 1 or 3 with wValue==0 and wIndex[3:0]<NUM_EP: clear or set ep_stall[wIndex[3:0]]; status_pending = 1.
  - A request targeting EP0 never sets ep_stall[0].
  - Anything else: ep_stall[0] = 1; status_pending = 0.
  - Request side effects other than the address commit apply immediately.
- TX_HS: data_o=handshake PID and start_stop=1 for one cycle, then TX_HS_END.
  - TX_HS_END: when data_o_strb, pulse start_stop and go to IDLE.
  - data_o_fail: go to IDLE.
- IDLE, IN/OUT to endpoint n with ep_stall[n]: TX_HS with PID_STALL (OUT data is drained first in DRAIN).
- IDLE, IN to EP0 with status_pending: go to TX_ZLP.
  - TX_ZLP: data_o=PID_DATA1, start_stop for 1 cycle.
  - Then wait data_o_strb and pulse start_stop.
  - Then WAIT_ACK: load timeout counter.
- WAIT_ACK: on token_in_strb with PID_ACK: dev_addr <= pending_addr (only if the request was SET_ADDRESS); status_pending = 0; go to IDLE.
  - On timeout expiry or any other token: go to IDLE with status_pending kept. The host retry re-sends the ZLP.
- Other IN/OUT to non-stalled endpoints: ignored. Traffic for EP≠0 is owned by the data-endpoint blocks.
- A new SETUP always overrides status_pending.
- Outputs data_o and data_o_start_stop are decoded combinationally from state and data_o_strb. All other outputs are registered.

Decomposition:
- Shared package usb_pkg: PID constants (OUT, IN, SOF, SETUP, DATA0/1/2, MDATA, ACK, NAK, STALL, NYET, PING), standard request codes, token field offsets.
- One sub-module: usb_hs_tx. It sequences a one-PID packet (start pulse, wait data_o_strb, stop pulse) and is reused for ACK, STALL and ZLP.

Test Plan:
- SETUP addr0/EP0 + DATA0 {00 05 2A 00 00 00 00 00} -> ACK out, setup_valid pulse. Then IN EP0 -> DATA1 ZLP. Then host ACK -> dev_addr=0x2A. A following token to addr 0 is ignored.
- Same sequence, no host ACK for 1023 cycles -> dev_addr stays 0. Second IN -> ZLP re-sent. ACK -> dev_addr=0x2A.
- SETUP with {80 06 00 01 00 00 40 00} -> ACK, ep_stall[0]=1. IN EP0 -> STALL. New SETUP clears ep_stall[0].
- SET_FEATURE {02 03 00 00 01 00 00 00} -> ep_stall[1]=1. IN EP1 -> STALL. CLEAR_FEATURE -> ep_stall[1]=0.
- SETUP with 7 bytes, DATA1 pid, or data_in_fail -> no handshake, state IDLE, outputs unchanged.
- nrst pulse during RX_SETUP byte 4 -> all outputs 0, next SETUP processed normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB constants: PIDs, standard request codes, token field offsets, FSM state types.
package usb_pkg;

  // Full 8-bit PIDs, including the complemented check nibble
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_NYET  = 8'h96;
  localparam logic [7:0] PID_PING  = 8'hB4;

  // Standard request codes and the request types this engine accepts
  localparam logic [7:0] REQ_CLEAR_FEATURE     = 8'd1;
  localparam logic [7:0] REQ_SET_FEATURE       = 8'd3;
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'd5;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'd9;
  localparam logic [7:0] RT_STD_DEV_OUT        = 8'h00;
  localparam logic [7:0] RT_STD_EP_OUT         = 8'h02;

  // Token field LSB positions
  localparam int unsigned TOK_PID_LSB  = 0;
  localparam int unsigned TOK_ADDR_LSB = 8;
  localparam int unsigned TOK_EP_LSB   = 15;
  localparam int unsigned TOK_CRC_LSB  = 19;

  typedef enum logic [2:0] {StIdle, StRxSetup, StDrain, StTx, StWaitAck} ctrl_state_e;
  typedef enum logic [1:0] {HsIdle, HsStart, HsEnd} hs_state_e;

endpackage

// File: rtl/usb_hs_tx.sv
// One-PID packet sequencer: start pulse carrying the PID, wait for the transmitter, stop pulse.
module usb_hs_tx
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] pid_in,
  input  logic       data_o_strb,
  input  logic       data_o_fail,
  output logic [7:0] data_o,
  output logic       data_o_start_stop,
  output logic       done,
  output logic       ok
);

  hs_state_e  state_q, state_d;
  logic [7:0] pid_q;

  // State register and PID latch
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= HsIdle;
      pid_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (start) pid_q <= pid_in;
    end
  end

  // Next state and transmitter-facing outputs
  always_comb begin
    state_d           = state_q;
    data_o            = 8'h00;
    data_o_start_stop = 1'b0;
    done              = 1'b0;
    ok                = 1'b0;
    unique case (state_q)
      HsIdle: if (start) state_d = HsStart;
      HsStart: begin
        data_o            = pid_q;
        data_o_start_stop = 1'b1;
        if (data_o_fail) begin
          done    = 1'b1;
          state_d = HsIdle;
        end else begin
          state_d = HsEnd;
        end
      end
      HsEnd: begin
        if (data_o_fail) begin
          done    = 1'b1;
          state_d = HsIdle;
        end else if (data_o_strb) begin
          data_o_start_stop = 1'b1;
          done              = 1'b1;
          ok                = 1'b1;
          state_d           = HsIdle;
        end
      end
      default: state_d = HsIdle;
    endcase
  end

endmodule

// File: rtl/usb_ctrl_ep.sv
// Control endpoint engine: receives SETUP, executes no-data standard requests, runs status stage.
module usb_ctrl_ep
  import usb_pkg::*;
#(
  parameter int unsigned NUM_EP  = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [23:0]       token_in,
  input  logic              token_in_strb,
  input  logic [7:0]        data_in,
  input  logic              data_in_strb,
  input  logic              data_in_end,
  input  logic              data_in_fail,
  input  logic [7:0]        pid,
  output logic [7:0]        data_o,
  output logic              data_o_start_stop,
  input  logic              data_o_strb,
  input  logic              data_o_fail,
  output logic [6:0]        dev_addr,
  output logic              configured,
  output logic [NUM_EP-1:0] ep_stall,
  output logic [63:0]       setup_pkt,
  output logic              setup_valid
);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] buf_q, buf_d;
  logic [9:0]  tmr_q, tmr_d;
  logic        status_pending_q, status_pending_d;
  logic [6:0]  pend_addr_q, pend_addr_d;
  logic        addr_req_q, addr_req_d;
  logic        zlp_q, zlp_d;
  logic [6:0]  dev_addr_q, dev_addr_d;
  logic        configured_q, configured_d;
  logic [NUM_EP-1:0] ep_stall_q;
  logic [15:0] stall_ext, stall_d;
  logic [63:0] setup_pkt_q, setup_pkt_d;
  logic        setup_valid_d, setup_valid_q;
  logic        hs_start, hs_done, hs_ok;
  logic [7:0]  hs_pid;

  logic [7:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_ep;
  logic        tok_match;
  logic        unused_crc;

  assign tok_pid    = token_in[TOK_PID_LSB +: 8];
  assign tok_addr   = token_in[TOK_ADDR_LSB +: 7];
  assign tok_ep     = token_in[TOK_EP_LSB +: 4];
  assign unused_crc = ^token_in[TOK_CRC_LSB +: 5];
  assign tok_match  = token_in_strb && (tok_addr == dev_addr_q) && (32'(tok_ep) < NUM_EP);
  assign stall_ext  = 16'(ep_stall_q);

  // SETUP payload fields, valid once all 8 bytes are buffered
  logic [7:0]  bm_req_type, b_request;
  logic [15:0] w_value, w_index, w_length;
  assign bm_req_type = buf_q[7:0];
  assign b_request   = buf_q[15:8];
  assign w_value     = buf_q[31:16];
  assign w_index     = buf_q[47:32];
  assign w_length    = buf_q[63:48];

  // Control state and request-result registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= StIdle;
      cnt_q            <= 4'd0;
      buf_q            <= 64'd0;
      tmr_q            <= 10'd0;
      status_pending_q <= 1'b0;
      pend_addr_q      <= 7'd0;
      addr_req_q       <= 1'b0;
      zlp_q            <= 1'b0;
      dev_addr_q       <= 7'd0;
      configured_q     <= 1'b0;
      ep_stall_q       <= '0;
      setup_pkt_q      <= 64'd0;
      setup_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      buf_q            <= buf_d;
      tmr_q            <= tmr_d;
      status_pending_q <= status_pending_d;
      pend_addr_q      <= pend_addr_d;
      addr_req_q       <= addr_req_d;
      zlp_q            <= zlp_d;
      dev_addr_q       <= dev_addr_d;
      configured_q     <= configured_d;
      ep_stall_q       <= stall_d[NUM_EP-1:0];
      setup_pkt_q      <= setup_pkt_d;
      setup_valid_q    <= setup_valid_d;
    end
  end

  // Next-state logic, SETUP decode and handshake launch
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    buf_d            = buf_q;
    tmr_d            = tmr_q;
    status_pending_d = status_pending_q;
    pend_addr_d      = pend_addr_q;
    addr_req_d       = addr_req_q;
    zlp_d            = zlp_q;
    dev_addr_d       = dev_addr_q;
    configured_d     = configured_q;
    stall_d          = stall_ext;
    setup_pkt_d      = setup_pkt_q;
    setup_valid_d    = 1'b0;
    hs_start         = 1'b0;
    hs_pid           = PID_ACK;
    unique case (state_q)
      StIdle: begin
        if (tok_match) begin
          if (tok_pid == PID_SETUP && tok_ep == 4'd0) begin
            // A new SETUP abandons any unfinished status stage
            state_d          = StRxSetup;
            cnt_d            = 4'd0;
            status_pending_d = 1'b0;
          end else if ((tok_pid == PID_IN || tok_pid == PID_OUT) && stall_ext[tok_ep]) begin
            if (tok_pid == PID_OUT) begin
              state_d = StDrain;
            end else begin
              hs_start = 1'b1;
              hs_pid   = PID_STALL;
              zlp_d    = 1'b0;
              state_d  = StTx;
            end
          end else if (tok_pid == PID_IN && tok_ep == 4'd0 && status_pending_q) begin
            hs_start = 1'b1;
            hs_pid   = PID_DATA1;
            zlp_d    = 1'b1;
            state_d  = StTx;
          end
        end
      end
      StRxSetup: begin
        if (data_in_fail) begin
          state_d = StIdle;
        end else if (data_in_end) begin
          if (pid == PID_DATA0 && cnt_q == 4'd8) begin
            setup_valid_d = 1'b1;
            setup_pkt_d   = buf_q;
            stall_d[0]    = 1'b0;
            addr_req_d    = 1'b0;
            if (w_length == 16'd0 && bm_req_type == RT_STD_DEV_OUT &&
                b_request == REQ_SET_ADDRESS) begin
              pend_addr_d      = w_value[6:0];
              addr_req_d       = 1'b1;
              status_pending_d = 1'b1;
            end else if (w_length == 16'd0 && bm_req_type == RT_STD_DEV_OUT &&
                         b_request == REQ_SET_CONFIGURATION) begin
              configured_d     = |w_value[7:0];
              status_pending_d = 1'b1;
            end else if (w_length == 16'd0 && bm_req_type == RT_STD_EP_OUT &&
                         (b_request == REQ_CLEAR_FEATURE || b_request == REQ_SET_FEATURE) &&
                         w_value == 16'd0 && 32'(w_index[3:0]) < NUM_EP) begin
              // EP0 halt is cleared by every SETUP, so it is never set here
              if (w_index[3:0] != 4'd0) stall_d[w_index[3:0]] = (b_request == REQ_SET_FEATURE);
              status_pending_d = 1'b1;
            end else begin
              stall_d[0]       = 1'b1;
              status_pending_d = 1'b0;
            end
            hs_start = 1'b1;
            hs_pid   = PID_ACK;
            zlp_d    = 1'b0;
            state_d  = StTx;
          end else begin
            state_d = StIdle;
          end
        end else if (data_in_strb) begin
          if (cnt_q < 4'd8) buf_d[{cnt_q[2:0], 3'b000} +: 8] = data_in;
          if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
        end
      end
      StDrain: begin
        if (data_in_fail) begin
          state_d = StIdle;
        end else if (data_in_end) begin
          hs_start = 1'b1;
          hs_pid   = PID_STALL;
          zlp_d    = 1'b0;
          state_d  = StTx;
        end
      end
      StTx: begin
        if (hs_done) begin
          if (zlp_q && hs_ok) begin
            state_d = StWaitAck;
            tmr_d   = 10'(TIMEOUT);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitAck: begin
        if (token_in_strb) begin
          if (tok_pid == PID_ACK) begin
            if (addr_req_q) dev_addr_d = pend_addr_q;
            status_pending_d = 1'b0;
          end
          state_d = StIdle;
        end else if (tmr_q == 10'd0) begin
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q - 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  usb_hs_tx u_hs_tx (
    .clk               (clk),
    .nrst              (nrst),
    .start             (hs_start),
    .pid_in            (hs_pid),
    .data_o_strb       (data_o_strb),
    .data_o_fail       (data_o_fail),
    .data_o            (data_o),
    .data_o_start_stop (data_o_start_stop),
    .done              (hs_done),
    .ok                (hs_ok)
  );

  assign dev_addr    = dev_addr_q;
  assign configured  = configured_q;
  assign ep_stall    = ep_stall_q;
  assign setup_pkt   = setup_pkt_q;
  assign setup_valid = setup_valid_q;

endmodule

// File: tb/tb_usb_ctrl_ep.sv
// Self-checking bench for usb_ctrl_ep: directed control transfers plus randomized requests.
module tb_usb_ctrl_ep;
  import usb_pkg::*;

  localparam int unsigned NUM_EP = 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic [23:0]       token_in;
  logic              token_in_strb;
  logic [7:0]        data_in;
  logic              data_in_strb, data_in_end, data_in_fail;
  logic [7:0]        pid;
  logic [7:0]        data_o;
  logic              data_o_start_stop, data_o_strb, data_o_fail;
  logic [6:0]        dev_addr;
  logic              configured;
  logic [NUM_EP-1:0] ep_stall;
  logic [63:0]       setup_pkt;
  logic              setup_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, in terms of the protocol rather than the RTL
  int          m_addr, m_cfg, m_status, m_pend_addr, m_pend_is_addr, m_waiting;
  int          m_stall[16];
  logic [63:0] m_setup;

  usb_ctrl_ep #(.NUM_EP(NUM_EP), .TIMEOUT(1023)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .token_in          (token_in),
    .token_in_strb     (token_in_strb),
    .data_in           (data_in),
    .data_in_strb      (data_in_strb),
    .data_in_end       (data_in_end),
    .data_in_fail      (data_in_fail),
    .pid               (pid),
    .data_o            (data_o),
    .data_o_start_stop (data_o_start_stop),
    .data_o_strb       (data_o_strb),
    .data_o_fail       (data_o_fail),
    .dev_addr          (dev_addr),
    .configured        (configured),
    .ep_stall          (ep_stall),
    .setup_pkt         (setup_pkt),
    .setup_valid       (setup_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_addr = 0; m_cfg = 0; m_status = 0; m_pend_addr = 0; m_pend_is_addr = 0; m_waiting = 0;
    m_setup = 64'd0;
    for (int i = 0; i < 16; i++) m_stall[i] = 0;
  endfunction

  // Apply a good SETUP's request rules
  function automatic void model_setup(input logic [63:0] pkt);
    int bm, rq, wv, wi, wl, ep;
    bm = int'(pkt & 64'hFF);
    rq = int'((pkt >> 8) & 64'hFF);
    wv = int'((pkt >> 16) & 64'hFFFF);
    wi = int'((pkt >> 32) & 64'hFFFF);
    wl = int'((pkt >> 48) & 64'hFFFF);
    m_setup = pkt;
    m_stall[0] = 0;
    m_pend_is_addr = 0;
    if (wl == 0 && bm == 0 && rq == 5) begin
      m_pend_addr = wv % 128; m_pend_is_addr = 1; m_status = 1;
    end else if (wl == 0 && bm == 0 && rq == 9) begin
      m_cfg = ((wv % 256) != 0) ? 1 : 0; m_status = 1;
    end else if (wl == 0 && bm == 2 && (rq == 1 || rq == 3) && wv == 0 && (wi % 16) < NUM_EP) begin
      ep = wi % 16;
      if (ep != 0) m_stall[ep] = (rq == 3) ? 1 : 0;
      m_status = 1;
    end else begin
      m_stall[0] = 1; m_status = 0;
    end
  endfunction

  // Expected reply PID to an addressed IN/OUT token, 0 for silence
  function automatic int model_resp(input logic [7:0] tpid, input int ep);
    if (ep >= NUM_EP) return 0;
    if ((tpid == PID_IN || tpid == PID_OUT) && m_stall[ep] != 0) return int'(PID_STALL);
    if (tpid == PID_IN && ep == 0 && m_status != 0) return int'(PID_DATA1);
    return 0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [NUM_EP-1:0] es;
    for (int i = 0; i < NUM_EP; i++) es[i] = (m_stall[i] != 0);
    check({tag, " dev_addr"}, 64'(dev_addr), 64'(m_addr));
    check({tag, " configured"}, 64'(configured), 64'(m_cfg));
    check({tag, " ep_stall"}, 64'(ep_stall), 64'(es));
    check({tag, " setup_pkt"}, setup_pkt, m_setup);
  endtask

  task automatic send_token(input logic [7:0] tpid, input int addr, input int ep);
    token_in = {5'h00, 4'(ep), 7'(addr), tpid};
    token_in_strb = 1'b1;
    step();
    token_in_strb = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] pkt, input int n);
    for (int i = 0; i < n; i++) begin
      data_in = pkt[8*i +: 8];
      data_in_strb = 1'b1;
      step();
      data_in_strb = 1'b0;
    end
  endtask

  task automatic send_data(input logic [7:0] dpid, input logic [63:0] pkt, input int n,
                           input bit fail);
    pid = dpid;
    send_bytes(pkt, n);
    if (fail) data_in_fail = 1'b1;
    else data_in_end = 1'b1;
    step();
    data_in_fail = 1'b0;
    data_in_end = 1'b0;
  endtask

  // Act as the transmitter: find the start pulse, then consume and expect the stop pulse
  task automatic expect_pkt(input logic [7:0] exp_pid, input string tag);
    bit found = 1'b0;
    logic [7:0] got = 8'h00;
    for (int i = 0; i < 16 && !found; i++) begin
      #1;
      if (data_o_start_stop) begin
        found = 1'b1;
        got = data_o;
      end else begin
        step();
      end
    end
    check({tag, " start"}, 64'(found), 64'd1);
    check({tag, " pid"}, 64'(got), 64'(exp_pid));
    if (found) begin
      step();
      data_o_strb = 1'b1;
      #1;
      check({tag, " stop"}, 64'(data_o_start_stop), 64'd1);
      step();
      data_o_strb = 1'b0;
    end
  endtask

  task automatic expect_none(input string tag, input int ncyc);
    bit seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      if (data_o_start_stop) seen = 1'b1;
      step();
    end
    check({tag, " silent"}, 64'(seen), 64'd0);
  endtask

  task automatic do_setup(input logic [63:0] pkt, input string tag);
    send_token(PID_SETUP, m_addr, 0);
    m_status = 0;
    send_data(PID_DATA0, pkt, 8, 1'b0);
    model_setup(pkt);
    check({tag, " setup_valid"}, 64'(setup_valid), 64'd1);
    expect_pkt(PID_ACK, {tag, " ack"});
    check_outputs(tag);
  endtask

  task automatic do_in(input int ep, input string tag);
    int r;
    r = model_resp(PID_IN, ep);
    send_token(PID_IN, m_addr, ep);
    if (r == 0) begin
      expect_none(tag, 8);
    end else begin
      expect_pkt(8'(r), tag);
      if (r == int'(PID_DATA1)) m_waiting = 1;
    end
  endtask

  // Finish a status stage with a host ACK, or abandon it with an unrelated token
  task automatic do_status(input bit ack, input string tag);
    if (ack) begin
      send_token(PID_ACK, 0, 0);
      if (m_waiting != 0) begin
        if (m_pend_is_addr != 0) m_addr = m_pend_addr;
        m_status = 0;
      end
    end else begin
      send_token(PID_SOF, 0, 0);
    end
    m_waiting = 0;
    check_outputs(tag);
  endtask

  logic [63:0] pkt;
  int          a, v, kind, ep;

  initial begin
    nrst = 1'b0;
    token_in = '0; token_in_strb = 1'b0;
    data_in = '0; data_in_strb = 1'b0; data_in_end = 1'b0; data_in_fail = 1'b0;
    pid = '0; data_o_strb = 1'b0; data_o_fail = 1'b0;
    model_reset();
    repeat (3) step();
    check_outputs("reset");
    check("reset data_o", 64'(data_o), 64'd0);
    check("reset start_stop", 64'(data_o_start_stop), 64'd0);
    check("reset setup_valid", 64'(setup_valid), 64'd0);
    nrst = 1'b1;
    step();

    // SET_ADDRESS 0x2A with a complete status stage
    do_setup(64'h0000_0000_002A_0500, "set_addr");
    do_in(0, "status_in");
    do_status(1'b1, "status_ack");
    check("new addr", 64'(dev_addr), 64'h2A);
    // Old address 0 no longer matches
    send_token(PID_SETUP, 0, 0);
    send_data(PID_DATA0, 64'h0000_0000_0011_0500, 8, 1'b0);
    check("old addr setup_valid", 64'(setup_valid), 64'd0);
    expect_none("old addr", 8);
    check_outputs("old addr");

    // Status stage times out, then the retry completes it
    a = $urandom_range(1, 127);
    pkt = 64'h0000_0000_0000_0500 | (64'(a) << 16);
    do_setup(pkt, "set_addr2");
    do_in(0, "zlp1");
    repeat (1100) step();
    m_waiting = 0;
    check_outputs("timeout");
    do_in(0, "zlp_retry");
    do_status(1'b1, "retry_ack");

    // Unsupported request stalls EP0 until the next SETUP
    do_setup(64'h0040_0000_0100_0680, "get_desc");
    do_in(0, "ep0_stall");
    v = $urandom_range(1, 255);
    pkt = 64'h0000_0000_0000_0900 | (64'(v) << 16);
    do_setup(pkt, "set_cfg");
    do_in(0, "cfg_zlp");
    do_status(1'b1, "cfg_ack");

    // Endpoint halt on EP1
    do_setup(64'h0000_0001_0000_0302, "set_halt");
    do_in(1, "ep1_in_stall");
    send_token(PID_OUT, m_addr, 1);
    send_data(PID_DATA0, {$urandom, $urandom}, $urandom_range(0, 8), 1'b0);
    expect_pkt(PID_STALL, "ep1_out_stall");
    do_setup(64'h0000_0001_0000_0102, "clr_halt");
    do_in(1, "ep1_in_quiet");
    do_in(0, "clr_zlp");
    do_status(1'b1, "clr_ack");

    // Malformed SETUP data stages produce no handshake and no side effects
    send_token(PID_SETUP, m_addr, 0);
    m_status = 0;
    send_data(PID_DATA0, 64'h0000_0000_0055_0500, 7, 1'b0);
    check("short setup_valid", 64'(setup_valid), 64'd0);
    expect_none("short", 8);
    check_outputs("short");
    send_token(PID_SETUP, m_addr, 0);
    send_data(PID_DATA1, 64'h0000_0000_0055_0500, 8, 1'b0);
    check("data1 setup_valid", 64'(setup_valid), 64'd0);
    expect_none("data1", 8);
    check_outputs("data1");
    send_token(PID_SETUP, m_addr, 0);
    send_data(PID_DATA0, 64'h0000_0000_0055_0500, 8, 1'b1);
    check("fail setup_valid", 64'(setup_valid), 64'd0);
    expect_none("fail", 8);
    check_outputs("fail");

    // Reset in the middle of a SETUP payload
    send_token(PID_SETUP, m_addr, 0);
    pid = PID_DATA0;
    send_bytes(64'h0000_0000_0066_0500, 4);
    nrst = 1'b0;
    step();
    model_reset();
    check_outputs("mid reset");
    check("mid reset start_stop", 64'(data_o_start_stop), 64'd0);
    nrst = 1'b1;
    step();
    a = $urandom_range(1, 127);
    pkt = 64'h0000_0000_0000_0500 | (64'(a) << 16);
    do_setup(pkt, "post_reset");
    do_in(0, "post_reset_zlp");
    do_status(1'b1, "post_reset_ack");

    // Randomized requests against the model
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: pkt = 64'h0000_0000_0000_0500 | (64'($urandom_range(0, 127)) << 16);
        1: pkt = 64'h0000_0000_0000_0900 | (64'($urandom_range(0, 255)) << 16);
        2: pkt = 64'h0000_0000_0000_0002 | (64'($urandom_range(0, 1) * 2 + 1) << 8)
                 | (64'($urandom_range(0, 3)) << 32);
        3: pkt = 64'h0000_0001_0000_0302 | (64'($urandom_range(1, 65535)) << 16);
        4: pkt = {$urandom, $urandom};
        default: pkt = 64'h0000_0000_0000_0500 | (64'($urandom_range(1, 255)) << 48);
      endcase
      do_setup(pkt, "rand_setup");
      ep = $urandom_range(0, 1);
      do_in(ep, "rand_in");
      if (m_waiting != 0) do_status(1'(($urandom_range(0, 1))), "rand_status");
      if (ep == 1) begin
        do_in(0, "rand_in0");
        if (m_waiting != 0) do_status(1'b1, "rand_status0");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
